regs_wb_arbiter: RTL and testbench
==================================

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, load-return buffer depth (power of two, >=2).
REQ-002 SHALL have parameter AGE_LIMIT, default 3, cycles a buffered load may wait before forced priority (>=1).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port i_alu_rd_addr  input  5  ALU destination register.
REQ-007 SHALL have port i_alu_rd_data  input  32  ALU result.
REQ-008 SHALL have port o_alu_ready  output  1  ALU request accepted this cycle when high with i_alu_valid.
REQ-009 SHALL have port i_ld_valid  input  1  load-return request.
REQ-010 SHALL have port i_ld_rd_addr  input  5  load destination register.
REQ-011 SHALL have port i_ld_rd_data  input  32  load data.
REQ-012 SHALL have port o_ld_ready  output  1  load buffer can accept.
REQ-013 SHALL have port o_rd_addr  output  5  register-file write address.
REQ-014 SHALL have port o_rd_data  output  32  register-file write data.
REQ-015 SHALL have port o_write_en  output  1  register-file write strobe.
REQ-016 SHALL have port o_pend_mask  output  32  bit n high while a buffered load targets xn; bit 0 always 0.

Function
REQ-017 SHALL accept a load (i_ld_valid & o_ld_ready) into FIFO tail; o_ld_ready = (registered count < FIFO_DEPTH), independent of same-cycle pop.
REQ-018 SHALL accept and discard loads with rd=0 (no enqueue, no write).
REQ-019 SHALL hold head age counter: 0 on new head, +1 per cycle head waits, saturating at AGE_LIMIT.
REQ-020 SHALL assert force when FIFO non-empty and head age == AGE_LIMIT.
REQ-021 SHALL drive o_alu_ready = !force & !(i_alu_rd_addr!=0 & o_pend_mask[i_alu_rd_addr]) (WAW guard: older buffered load to same rd drains first).
REQ-022 SHALL grant per cycle, priority order: force -> pop head; else accepted ALU with rd!=0 -> ALU; else FIFO non-empty -> pop head; else none.
REQ-023 SHALL treat accepted ALU with rd=0 as no port request (FIFO head may pop that cycle).
REQ-024 SHALL register the granted write: o_write_en/o_rd_addr/o_rd_data valid the cycle after grant (latency 1 ALU, minimum 2 for loads); o_write_en=0 with address/data holding last value when no grant.
REQ-025 SHALL retire FIFO entries strictly in order; push and pop in same cycle allowed when not full.
REQ-026 SHALL update o_pend_mask from registered FIFO contents (combinational OR of valid entries' rd decode).
REQ-027 SHALL never assert o_write_en with o_rd_addr=0.

Reset
REQ-028 SHALL on i_rst_n low, asynchronously clear FIFO count/pointers, age, o_write_en, o_rd_addr, o_rd_data to 0; o_ld_ready=1, o_pend_mask=0 while in reset.
REQ-029 SHALL discard buffered loads on reset mid-operation; no write issued after release until a new grant.

Structure
REQ-030 SHALL take XLEN=32 and REG_ADDR_W=5 constants from shared package regs_pkg.
REQ-031 SHALL instantiate one sub-module wb_fifo (parameterized depth, {addr,data} entries, count output, entry-valid/addr vector for mask).

Verification
REQ-032 ALU only: alu valid rd=5 data 0x11 -> next cycle write_en=1 addr 5 data 0x11.
REQ-033 Contention: load rd=7 0xAA then ALU valid rd=3 every cycle -> ALU wins 3 cycles, cycle 4 o_alu_ready=0, load written, x7 pend bit clears.
REQ-034 WAW: load rd=9 buffered, ALU rd=9 -> o_alu_ready=0 until load write issued, then ALU write to 9 follows, final value ALU data.
REQ-035 Full: 2 loads buffered with ALU busy -> o_ld_ready=0; third load held until pop cycle +1.
REQ-036 rd=0: ALU rd=0 and load rd=0 -> both accepted, no write_en, pend_mask=0.
REQ-037 Reset mid-op: 2 loads buffered, pulse i_rst_n low asynchronously -> outputs 0, pend_mask 0, no later write of those loads.

Source files
------------

// File: rtl/regs_pkg.sv
// -----------------------------------------------------------------------------
// regs_pkg
// Shared register-file constants and types used by the writeback arbiter
// and its load-return buffer.
//   XLEN        - data path width
//   REG_ADDR_W  - register address width
//   NUM_REGS    - number of architectural registers
//   wb_entry_t  - one buffered writeback {addr, data}
//   grant_t     - which source owns the register-file write port this cycle
//   rd_decode() - one-hot decode of a destination register (x0 decodes to 0)
// -----------------------------------------------------------------------------
package regs_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LOAD = 2'd2
    } grant_t;

    // x0 is hardwired to zero, so it never contributes a pending bit.
    function automatic logic [NUM_REGS-1:0] rd_decode(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] onehot;
        onehot = '0;
        if (addr != '0) begin
            onehot[addr] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order buffer of load-return writebacks waiting for the register-file
// write port.
//   i_clk, i_rst_n      - clock, asynchronous active-low reset (pointers/count)
//   i_push/_addr/_data  - enqueue one entry at the tail (caller ensures not full)
//   i_pop               - retire the head entry (caller ensures not empty)
//   o_head_addr/_data   - current head entry
//   o_count             - number of valid entries (registered)
//   o_entry_valid       - per-slot valid flag, derived from pointers and count
//   o_entry_addr        - per-slot destination register, packed slot-major
// -----------------------------------------------------------------------------
module wb_fifo
    import regs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic [REG_ADDR_W-1:0]       i_push_addr,
    input  logic [XLEN-1:0]             i_push_data,
    input  logic                        i_pop,
    output logic [REG_ADDR_W-1:0]       o_head_addr,
    output logic [XLEN-1:0]             o_head_data,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [DEPTH-1:0]            o_entry_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] o_entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Entry storage carries no reset: validity comes only from the pointers.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr_reg] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head_addr = mem[rd_ptr_reg].addr;
    assign o_head_data = mem[rd_ptr_reg].data;
    assign o_count     = count_reg;

    // A slot is live when its distance from the head (mod DEPTH, which wraps
    // naturally because DEPTH is a power of two) is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_offset;
            assign slot_offset       = PTR_W'(gi) - rd_ptr_reg;
            assign o_entry_valid[gi] = ({1'b0, slot_offset} < count_reg);
            assign o_entry_addr[gi*REG_ADDR_W +: REG_ADDR_W] = mem[gi].addr;
        end
    endgenerate

endmodule

// File: rtl/regs_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regs_wb_arbiter
// Arbitrates the single register-file write port between the ALU and a
// buffered load-return path. The ALU normally wins; a buffered load that has
// waited AGE_LIMIT cycles forces its way through. An ALU write to a register
// that still has an older buffered load pending is stalled so the writes land
// in program order.
//   i_clk, i_rst_n                 - clock, asynchronous active-low reset
//   i_alu_valid/_rd_addr/_rd_data  - ALU writeback request
//   o_alu_ready                    - ALU request accepted when high with valid
//   i_ld_valid/_rd_addr/_rd_data   - load-return request
//   o_ld_ready                     - load buffer has room
//   o_rd_addr/_rd_data/o_write_en  - registered register-file write
//   o_pend_mask                    - registers targeted by buffered loads
// -----------------------------------------------------------------------------
module regs_wb_arbiter
    import regs_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int AGE_LIMIT  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
    input  logic [XLEN-1:0]       i_alu_rd_data,
    output logic                  o_alu_ready,
    input  logic                  i_ld_valid,
    input  logic [REG_ADDR_W-1:0] i_ld_rd_addr,
    input  logic [XLEN-1:0]       i_ld_rd_data,
    output logic                  o_ld_ready,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_write_en,
    output logic [NUM_REGS-1:0]   o_pend_mask
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [CNT_W-1:0]                 fifo_count;
    logic [FIFO_DEPTH-1:0]            entry_valid;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0] entry_addr;
    logic [REG_ADDR_W-1:0]            head_addr;
    logic [XLEN-1:0]                  head_data;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;

    logic [AGE_W-1:0]                 age_reg;
    logic                             force_pop;
    logic                             waw_block;
    logic                             alu_accept;
    grant_t                           grant;

    logic                             write_en_reg;
    logic [REG_ADDR_W-1:0]            rd_addr_reg;
    logic [XLEN-1:0]                  rd_data_reg;

    logic [NUM_REGS-1:0]              slot_mask [FIFO_DEPTH];
    logic [NUM_REGS-1:0]              pend_mask;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_push        (fifo_push),
        .i_push_addr   (i_ld_rd_addr),
        .i_push_data   (i_ld_rd_data),
        .i_pop         (fifo_pop),
        .o_head_addr   (head_addr),
        .o_head_data   (head_data),
        .o_count       (fifo_count),
        .o_entry_valid (entry_valid),
        .o_entry_addr  (entry_addr)
    );

    assign fifo_empty = (fifo_count == '0);

    // Readiness looks only at the registered count, so a load can never be
    // offered room that depends on this cycle's pop decision.
    assign o_ld_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

    // Loads to x0 are accepted and silently dropped.
    assign fifo_push  = i_ld_valid & o_ld_ready & (i_ld_rd_addr != '0);

    // Pending-register mask: OR of each live slot's one-hot destination.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
            assign slot_mask[gi] = entry_valid[gi]
                                 ? rd_decode(entry_addr[gi*REG_ADDR_W +: REG_ADDR_W])
                                 : '0;
        end
    endgenerate

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pend_mask = pend_mask | slot_mask[i];
        end
    end

    assign o_pend_mask = pend_mask;

    assign force_pop   = !fifo_empty && (age_reg == AGE_W'(AGE_LIMIT));
    assign waw_block   = (i_alu_rd_addr != '0) && pend_mask[i_alu_rd_addr];
    assign o_alu_ready = !force_pop && !waw_block;
    assign alu_accept  = i_alu_valid && o_alu_ready;

    // An accepted ALU write to x0 consumes no port slot, leaving it for the
    // load buffer.
    always_comb begin
        grant = GRANT_NONE;
        if (force_pop) begin
            grant = GRANT_LOAD;
        end else if (alu_accept && (i_alu_rd_addr != '0)) begin
            grant = GRANT_ALU;
        end else if (!fifo_empty) begin
            grant = GRANT_LOAD;
        end
    end

    assign fifo_pop = (grant == GRANT_LOAD);

    // Head age restarts whenever a different entry becomes head (pop, or the
    // buffer was empty) and otherwise counts up to the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age_reg <= '0;
        end else if (fifo_pop || fifo_empty) begin
            age_reg <= '0;
        end else if (age_reg != AGE_W'(AGE_LIMIT)) begin
            age_reg <= age_reg + AGE_W'(1);
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_en_reg <= 1'b0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
        end else begin
            write_en_reg <= (grant != GRANT_NONE);
            if (grant == GRANT_ALU) begin
                rd_addr_reg <= i_alu_rd_addr;
                rd_data_reg <= i_alu_rd_data;
            end else if (grant == GRANT_LOAD) begin
                rd_addr_reg <= head_addr;
                rd_data_reg <= head_data;
            end
        end
    end

    assign o_write_en = write_en_reg;
    assign o_rd_addr  = rd_addr_reg;
    assign o_rd_data  = rd_data_reg;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
module tb_regs_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int AGE   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        write_en;
    logic [31:0] pend_mask;

    regs_wb_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .AGE_LIMIT  (AGE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alu_valid   (alu_valid),
        .i_alu_rd_addr (alu_addr),
        .i_alu_rd_data (alu_data),
        .o_alu_ready   (alu_ready),
        .i_ld_valid    (ld_valid),
        .i_ld_rd_addr  (ld_addr),
        .i_ld_rd_data  (ld_data),
        .o_ld_ready    (ld_ready),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_write_en    (write_en),
        .o_pend_mask   (pend_mask)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: loads waiting in arrival order, how long the current
    // head has waited, and the write the port should show after each edge.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          head_wait = 0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] reg_file [32];
    logic        obs_ardy;
    logic        obs_lrdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_mask();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].a] = 1'b1;
        return m;
    endfunction

    function automatic void mdl_reset();
        q.delete();
        head_wait = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
    endfunction

    // One clock of stimulus: apply inputs, check handshake outputs against the
    // model, advance the model across the edge, then check the write port.
    task automatic step(input string tag,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        logic [31:0] m_mask;
        logic        m_force, m_ardy, m_lrdy, had_head, popped;
        ent_t        e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ld;
        #1;
        m_mask  = mdl_mask();
        m_force = (q.size() > 0) && (head_wait >= AGE);
        m_ardy  = !m_force && !((aa != 0) && m_mask[aa]);
        m_lrdy  = (q.size() < DEPTH);
        obs_ardy = alu_ready;
        obs_lrdy = ld_ready;
        chk({tag, "_alu_ready"}, {31'b0, alu_ready}, {31'b0, m_ardy});
        chk({tag, "_ld_ready"},  {31'b0, ld_ready},  {31'b0, m_lrdy});
        chk({tag, "_pend"},      pend_mask,          m_mask);

        had_head = (q.size() > 0);
        popped   = 1'b0;
        if (m_force) begin
            e = q.pop_front(); popped = 1'b1;
            exp_we = 1'b1; exp_addr = e.a; exp_data = e.d;
        end else if (av && m_ardy && aa != 0) begin
            exp_we = 1'b1; exp_addr = aa; exp_data = ad;
        end else if (q.size() > 0) begin
            e = q.pop_front(); popped = 1'b1;
            exp_we = 1'b1; exp_addr = e.a; exp_data = e.d;
        end else begin
            exp_we = 1'b0;
        end
        if (popped || !had_head) head_wait = 0;
        else if (head_wait < AGE) head_wait++;
        if (lv && m_lrdy && la != 0) begin
            e.a = la; e.d = ld;
            q.push_back(e);
        end

        @(posedge clk);
        #1;
        chk({tag, "_we"},   {31'b0, write_en}, {31'b0, exp_we});
        chk({tag, "_addr"}, {27'b0, rd_addr},  {27'b0, exp_addr});
        chk({tag, "_data"}, rd_data,           exp_data);
        if (write_en) reg_file[rd_addr] = rd_data;
        $display("step %-12s alu=%0b/%0d ld=%0b/%0d ardy=%0b lrdy=%0b -> we=%0b rd=%0d data=%08h pend=%08h",
                 tag, av, aa, lv, la, obs_ardy, obs_lrdy, write_en, rd_addr, rd_data, pend_mask);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int blocked;
        bit accepted;
        foreach (reg_file[i]) reg_file[i] = '0;

        // Reset state
        #2;
        chk("rst_we",    {31'b0, write_en}, 32'd0);
        chk("rst_addr",  {27'b0, rd_addr},  32'd0);
        chk("rst_data",  rd_data,           32'd0);
        chk("rst_lrdy",  {31'b0, ld_ready}, 32'd1);
        chk("rst_pend",  pend_mask,         32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU only: write appears one cycle later
        step("alu_only", 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        chk("alu_only_we",   {31'b0, write_en}, 32'd1);
        chk("alu_only_addr", {27'b0, rd_addr},  32'd5);
        chk("alu_only_data", rd_data,           32'h11);
        idle("alu_idle");
        chk("idle_hold_addr", {27'b0, rd_addr}, 32'd5);

        // Contention: ALU wins three cycles, then the aged load is forced
        step("cont_ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        chk("cont_pend7", pend_mask, 32'h80);
        for (int k = 1; k <= 3; k++) begin
            step("cont_alu", 1'b1, 5'd3, 32'h300 + k, 1'b0, 5'd0, 32'd0);
            chk("cont_alu_addr", {27'b0, rd_addr}, 32'd3);
        end
        step("cont_force", 1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
        chk("cont_force_ardy", {31'b0, obs_ardy}, 32'd0);
        chk("cont_force_addr", {27'b0, rd_addr},  32'd7);
        chk("cont_force_data", rd_data,           32'hAA);
        chk("cont_pend_clear", pend_mask,         32'd0);
        step("cont_retry", 1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
        chk("cont_retry_data", rd_data, 32'h304);

        // WAW: ALU to a register with a buffered load waits for the load
        step("waw_ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        step("waw_stall", 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
        chk("waw_stall_ardy", {31'b0, obs_ardy}, 32'd0);
        chk("waw_ld_data",    rd_data,           32'h99);
        step("waw_alu", 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
        chk("waw_alu_ardy", {31'b0, obs_ardy}, 32'd1);
        chk("waw_final",    reg_file[9],       32'h55);

        // Full: two loads buffered while the ALU keeps the port busy
        step("full_ld1", 1'b1, 5'd4, 32'h41, 1'b1, 5'd12, 32'hC1);
        step("full_ld2", 1'b1, 5'd4, 32'h42, 1'b1, 5'd13, 32'hC2);
        blocked = 0;
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            step("full_ld3", 1'b1, 5'd4, 32'h43, 1'b1, 5'd14, 32'hC3);
            if (obs_lrdy) accepted = 1'b1;
            else blocked++;
        end
        chk("full_accepted", {31'b0, accepted}, 32'd1);
        chk("full_blocked",  blocked,           32'd3);
        for (int i = 0; i < 4; i++) idle("full_drain");
        chk("full_reg12", reg_file[12], 32'hC1);
        chk("full_reg14", reg_file[14], 32'hC3);

        // Writes to x0 are accepted and dropped
        step("rd0", 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        chk("rd0_ardy", {31'b0, obs_ardy}, 32'd1);
        chk("rd0_lrdy", {31'b0, obs_lrdy}, 32'd1);
        chk("rd0_we",   {31'b0, write_en}, 32'd0);
        chk("rd0_pend", pend_mask,         32'd0);

        // Reset mid-operation discards buffered loads
        step("rst_ld1", 1'b1, 5'd4, 32'h51, 1'b1, 5'd20, 32'hE0);
        step("rst_ld2", 1'b1, 5'd4, 32'h52, 1'b1, 5'd21, 32'hE1);
        chk("rst_pre_pend", pend_mask, 32'h0030_0000);
        alu_valid = 1'b0; ld_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   {31'b0, write_en}, 32'd0);
        chk("mid_rst_addr", {27'b0, rd_addr},  32'd0);
        chk("mid_rst_data", rd_data,           32'd0);
        chk("mid_rst_pend", pend_mask,         32'd0);
        chk("mid_rst_lrdy", {31'b0, ld_ready}, 32'd1);
        mdl_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) idle("post_rst");
        chk("post_rst_reg20", reg_file[20], 32'd0);
        chk("post_rst_reg21", reg_file[21], 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 6; i++) idle("rand_drain");
        chk("rand_drained_pend", pend_mask, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
